// File: rtl/vpu_alu_si_mul_seq.sv
// Iterative radix-2 Booth signed multiplier for the VPU signed-integer lane.
// One Booth step per clock; full 2*OPERAND_WIDTH product returned under valid/ready.
module vpu_alu_si_mul_seq #(
  parameter int OPERAND_WIDTH = 32  // even, >= 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [OPERAND_WIDTH-1:0] op_0,
  input  logic [OPERAND_WIDTH-1:0] op_1,
  input  logic                     en,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OPERAND_WIDTH-1:0] result_o,
  output logic [OPERAND_WIDTH-1:0] result_hi_o
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  m;
  logic [W-1:0]  q;
  logic [W:0]    a;     // one guard bit so -M of the most negative M cannot overflow
  logic          q_m1;
  logic [CW-1:0] cnt;
  logic [W:0]    msx;
  logic [W:0]    sum;

  assign msx = {m[W-1], m};

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + msx;
      2'b10:   sum = a - msx;
      default: sum = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      a     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          state <= BUSY;
          m     <= en ? op_0 : '0;
          q     <= en ? op_1 : '0;
          a     <= '0;
          q_m1  <= 1'b0;
          cnt   <= '0;
        end
        BUSY: begin
          // arithmetic shift of {A,Q,q_m1} applied to the post-add A
          a    <= {sum[W], sum[W:1]};
          q    <= {sum[0], q[W-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state == IDLE);
  assign valid_o     = (state == DONE);
  assign result_o    = q;
  assign result_hi_o = a[W-1:0];

endmodule

// File: tb/tb_vpu_alu_si_mul_seq.sv
// Randomized bench for vpu_alu_si_mul_seq against a 64-bit signed product model.
module tb_vpu_alu_si_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, en, valid_o, ready_i;
  logic [31:0] op_0, op_1, result_o, result_hi_o;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpu_alu_si_mul_seq #(.OPERAND_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_0(op_0), .op_1(op_1), .en(en), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .result_hi_o(result_hi_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit e);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return e ? 64'(sx * sy) : 64'd0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Present a pair and return just after the accepting edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit e);
    int n = 0;
    @(negedge clk);
    op_0 = x; op_1 = y; en = e; valid_i = 1'b1;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("accept_timeout", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_0 = $urandom; op_1 = $urandom; en = 1'($urandom);
  endtask

  // Called just after an accepting edge: measure latency, check product,
  // optionally stall (and present a held pair mid-stall), then consume.
  task automatic collect(input logic [63:0] exp, input bit early, input int stall,
                         input bit hold, input logic [31:0] ha, input logic [31:0] hb);
    int n = 0;
    ready_i = early;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!valid_o && n < 100);
    chk("latency", 64'(n), 64'd32);
    chk("valid_rise", 64'(valid_o), 64'd1);
    chk("product", {result_hi_o, result_o}, exp);
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        if (hold && i == 2) begin
          op_0 = ha; op_1 = hb; en = 1'b1; valid_i = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("stall_valid", 64'(valid_o), 64'd1);
        chk("stall_product", {result_hi_o, result_o}, exp);
        if (hold && i >= 2) chk("stall_ready", 64'(ready_o), 64'd0);
      end
      ready_i = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("consumed_valid", 64'(valid_o), 64'd0);
    chk("idle_ready", 64'(ready_o), 64'd1);
    ready_i = 1'($urandom);
  endtask

  initial begin
    logic [31:0] x, y;
    bit e;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; en = 1'b0; op_0 = '0; op_1 = '0;
    #12;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", {result_hi_o, result_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(32'd7, -32'sd3, 1'b1);
    collect(64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 0, 1'b0, '0, '0);
    launch(32'h8000_0000, 32'h8000_0000, 1'b1);
    collect(64'h4000_0000_0000_0000, 1'b1, 0, 1'b0, '0, '0);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    collect(64'h0000_0000_0000_0001, 1'b0, 2, 1'b0, '0, '0);
    launch(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    collect(64'hC000_0000_8000_0000, 1'b0, 0, 1'b0, '0, '0);
    launch(32'd5, 32'd9, 1'b0);
    collect(64'd0, 1'b1, 0, 1'b0, '0, '0);

    // backpressure with a held pair presented during the stall window
    launch(32'd1000, -32'sd77, 1'b1);
    collect(ref_mul(32'd1000, -32'sd77, 1'b1), 1'b0, 10, 1'b1, -32'sd6, 32'd11);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    collect(ref_mul(-32'sd6, 32'd11, 1'b1), 1'b1, 0, 1'b0, '0, '0);

    // reset during iteration 15
    launch(32'h1234, 32'h5678, 1'b1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_result", {result_hi_o, result_o}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_hold_valid", 64'(valid_o), 64'd0);
    end
    rst_n = 1'b1;
    launch(32'd3, 32'd4, 1'b1);
    collect(64'd12, 1'b1, 0, 1'b0, '0, '0);

    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      x = pick();
      y = pick();
      e = ($urandom_range(0, 7) != 0);
      launch(x, y, e);
      collect(ref_mul(x, y, e), 1'($urandom), int'($urandom_range(0, 4)), 1'b0, '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
